// File: rtl/stage_win_tracker.sv
// stage_win_tracker
//   Tracks the victory condition of the current game stage and emits a one-cycle
//   win_stage pulse after a frame-counted "stage clear" pause.
//     stages 1-2 : kill MONST_S1 / MONST_S2 monsters
//     stage 3    : survive ASTERO_FRAMES frames
//     stage 4    : land BOSS_HP hits on the boss
//
//   Ports
//     clk            system clock
//     reset          synchronous reset, active-high
//     frame_tick     one-cycle pulse per video frame
//     stage_num      current stage (0=INIT, 1..4 playable, 5=END_GAME)
//     monster_killed one-cycle pulse per monster destroyed
//     boss_hit       one-cycle pulse per boss hit
//     skip_stage     debug skip (present only when STAGE_SKIP_EN is defined)
//     win_stage      one-cycle pulse: current stage won
//     stage_clear    high while the clear pause runs
//     remaining      objective units left (monsters / frames / boss HP)
//
//   Build option: define STAGE_SKIP_EN to add the skip_stage debug input.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   S_IDLE     | no playable stage selected
//   S_LOAD     | latch stage_num, load its objective count
//   S_ACTIVE   | counting objective events down to zero
//   S_CLEARING | objective met, clear pause counting frames
//   S_WIN      | win_stage pulse cycle
//   S_WAIT_ADV | stage won, waiting for stage_num to move on

module stage_win_tracker #(
    parameter int CNT_W         = 10,
    parameter int MONST_S1      = 32,
    parameter int MONST_S2      = 40,
    parameter int ASTERO_FRAMES = 600,
    parameter int BOSS_HP       = 16,
    parameter int CLEAR_DELAY   = 120
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic [2:0]       stage_num,
    input  logic             monster_killed,
    input  logic             boss_hit,
`ifdef STAGE_SKIP_EN
    input  logic             skip_stage,
`endif
    output logic             win_stage,
    output logic             stage_clear,
    output logic [CNT_W-1:0] remaining
);

    localparam int CNT_LIMIT = 1 << CNT_W;

    // Objective counts must fit the counters; a wrapped load would silently
    // shorten a stage.
    if (MONST_S1 >= CNT_LIMIT || MONST_S2 >= CNT_LIMIT || ASTERO_FRAMES >= CNT_LIMIT ||
        BOSS_HP >= CNT_LIMIT || CLEAR_DELAY >= CNT_LIMIT) begin : g_param_check
        $error("stage_win_tracker: objective parameter does not fit in CNT_W bits");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACTIVE,
        S_CLEARING,
        S_WIN,
        S_WAIT_ADV
    } state_t;

    state_t           state, state_d;
    logic [2:0]       stage_q, stage_d;
    logic [CNT_W-1:0] rem_d;
    logic [CNT_W-1:0] delay_q, delay_d;
    logic             win_d, clear_d;
    logic             stage_ok;
    logic             stage_moved;
    logic             dec_evt;
    logic             skip_req;
    logic             obj_done;

    assign stage_ok    = (stage_num >= 3'd1) && (stage_num <= 3'd4);
    assign stage_moved = (stage_num != stage_q);

`ifdef STAGE_SKIP_EN
    assign skip_req = skip_stage;
`else
    assign skip_req = 1'b0;
`endif

    // Only the event type belonging to the latched stage counts down.
    always_comb begin
        dec_evt = 1'b0;
        case (stage_q)
            3'd1, 3'd2: dec_evt = monster_killed;
            3'd3:       dec_evt = frame_tick;
            3'd4:       dec_evt = boss_hit;
            default:    dec_evt = 1'b0;
        endcase
    end

    // Terminal count: already zero (zero-sized objective), last unit consumed,
    // or debug skip.
    assign obj_done = skip_req || (remaining == '0) ||
                      (dec_evt && (remaining == CNT_W'(1)));

    function automatic logic [CNT_W-1:0] goal_of(input logic [2:0] s);
        case (s)
            3'd1:    goal_of = CNT_W'(MONST_S1);
            3'd2:    goal_of = CNT_W'(MONST_S2);
            3'd3:    goal_of = CNT_W'(ASTERO_FRAMES);
            3'd4:    goal_of = CNT_W'(BOSS_HP);
            default: goal_of = '0;
        endcase
    endfunction

    // State register (with datapath registers and registered outputs)
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            stage_q     <= 3'd0;
            remaining   <= '0;
            delay_q     <= '0;
            win_stage   <= 1'b0;
            stage_clear <= 1'b0;
        end else begin
            state       <= state_d;
            stage_q     <= stage_d;
            remaining   <= rem_d;
            delay_q     <= delay_d;
            win_stage   <= win_d;
            stage_clear <= clear_d;
        end
    end

    // Next-state logic. A stage change always wins over a count reaching zero.
    always_comb begin
        state_d = state;
        stage_d = stage_q;
        rem_d   = remaining;
        delay_d = delay_q;
        if (stage_num == 3'd0) begin
            state_d = S_IDLE;
            rem_d   = '0;
            delay_d = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (stage_ok) state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (stage_ok) begin
                        stage_d = stage_num;
                        rem_d   = goal_of(stage_num);
                        state_d = S_ACTIVE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ACTIVE: begin
                    if (stage_moved) begin
                        state_d = stage_ok ? S_LOAD : S_IDLE;
                    end else if (obj_done) begin
                        rem_d   = '0;
                        delay_d = CNT_W'(CLEAR_DELAY);
                        state_d = S_CLEARING;
                    end else if (dec_evt) begin
                        rem_d = remaining - CNT_W'(1);
                    end
                end
                S_CLEARING: begin
                    if (stage_moved) begin
                        state_d = stage_ok ? S_LOAD : S_IDLE;
                    end else if (delay_q == '0) begin
                        state_d = S_WIN;
                    end else if (frame_tick) begin
                        delay_d = delay_q - CNT_W'(1);
                    end
                end
                S_WIN: begin
                    state_d = S_WAIT_ADV;
                end
                S_WAIT_ADV: begin
                    if (stage_moved) state_d = stage_ok ? S_LOAD : S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output logic, computed from the next state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        win_d   = (state_d == S_WIN);
        clear_d = (state_d == S_CLEARING);
    end

endmodule
